// File: rtl/viterbi_pkg.sv
// Shared constants for the K=3 (7,5) Viterbi decoder: state encodings,
// branch indices and the trellis predecessor table used by the ACS stage.
package viterbi_pkg;

  localparam int PM_W_DEF      = 8;
  localparam int INIT_PM_DEF   = 16;
  localparam int FRAME_LEN_DEF = 8;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_e;

  localparam int B1 = 0;
  localparam int B2 = 1;
  localparam int B3 = 2;
  localparam int B4 = 3;
  localparam int B5 = 4;
  localparam int B6 = 5;
  localparam int B7 = 6;
  localparam int B8 = 7;

  // Per destination state: first/second predecessor and the branch from each.
  localparam state_e PRED_A [4] = '{S0, S2, S0, S2};
  localparam state_e PRED_B [4] = '{S1, S3, S1, S3};
  localparam int     BR_A   [4] = '{B1, B3, B2, B4};
  localparam int     BR_B   [4] = '{B5, B7, B6, B8};

endpackage

// File: rtl/acs_cell.sv
// One add-compare-select cell: two candidate sums, full-width compare,
// survivor select and decision bit (ties keep the first candidate).
module acs_cell #(
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [1:0]      bm_a,
  input  logic [1:0]      bm_b,
  output logic [PM_W-1:0] pm_sel,
  output logic            dec
);

  logic [PM_W:0] sum_a;
  logic [PM_W:0] sum_b;

  assign sum_a = {1'b0, pm_a} + {{(PM_W-1){1'b0}}, bm_a};
  assign sum_b = {1'b0, pm_b} + {{(PM_W-1){1'b0}}, bm_b};

  // Normalisation upstream keeps the winner below 2^PM_W, so dropping the carry is safe.
  assign dec    = (sum_b < sum_a);
  assign pm_sel = dec ? sum_b[PM_W-1:0] : sum_a[PM_W-1:0];

endmodule

// File: rtl/acs_unit.sv
// ACS stage of the rate-1/2 K=3 Viterbi decoder: four path metrics with
// MSB normalisation, survivor decisions, best-state argmin and frame counter.
module acs_unit
  import viterbi_pkg::*;
#(
  parameter int PM_W      = PM_W_DEF,
  parameter int INIT_PM   = INIT_PM_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init,
  input  logic            hamd_valid,
  input  logic [1:0]      hamd_1,
  input  logic [1:0]      hamd_2,
  input  logic [1:0]      hamd_3,
  input  logic [1:0]      hamd_4,
  input  logic [1:0]      hamd_5,
  input  logic [1:0]      hamd_6,
  input  logic [1:0]      hamd_7,
  input  logic [1:0]      hamd_8,
  output logic [PM_W-1:0] pm_0,
  output logic [PM_W-1:0] pm_1,
  output logic [PM_W-1:0] pm_2,
  output logic [PM_W-1:0] pm_3,
  output logic [3:0]      dec,
  output logic            dec_valid,
  output logic [1:0]      best_state,
  output logic [2:0]      step_cnt,
  output logic            frame_done
);

  localparam logic [2:0]      LAST_STEP = 3'(FRAME_LEN - 1);
  localparam logic [PM_W-1:0] PM_INIT   = PM_W'(INIT_PM);

  logic [1:0]      hamd   [8];
  logic [PM_W-1:0] pm_q   [4];
  logic [PM_W-1:0] sel    [4];
  logic [PM_W-1:0] norm   [4];
  logic [3:0]      dec_n;
  logic [1:0]      best_n;
  logic            all_high;
  logic [PM_W-1:0] min_v;

  assign hamd[0] = hamd_1;
  assign hamd[1] = hamd_2;
  assign hamd[2] = hamd_3;
  assign hamd[3] = hamd_4;
  assign hamd[4] = hamd_5;
  assign hamd[5] = hamd_6;
  assign hamd[6] = hamd_7;
  assign hamd[7] = hamd_8;

  assign pm_0 = pm_q[0];
  assign pm_1 = pm_q[1];
  assign pm_2 = pm_q[2];
  assign pm_3 = pm_q[3];

  for (genvar s = 0; s < 4; s++) begin : g_acs
    acs_cell #(.PM_W(PM_W)) u_cell (
      .pm_a   (pm_q[PRED_A[s]]),
      .pm_b   (pm_q[PRED_B[s]]),
      .bm_a   (hamd[BR_A[s]]),
      .bm_b   (hamd[BR_B[s]]),
      .pm_sel (sel[s]),
      .dec    (dec_n[s])
    );
  end

  // Subtracting 2^(PM_W-1) from every metric preserves their differences.
  always_comb begin
    all_high = 1'b1;
    for (int s = 0; s < 4; s++) begin
      all_high = all_high & sel[s][PM_W-1];
    end
    for (int s = 0; s < 4; s++) begin
      norm[s] = sel[s];
      if (all_high) norm[s][PM_W-1] = 1'b0;
    end
    best_n = 2'd0;
    min_v  = norm[0];
    for (int s = 1; s < 4; s++) begin
      if (norm[s] < min_v) begin
        min_v  = norm[s];
        best_n = 2'(s);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm_q[0]    <= '0;
      pm_q[1]    <= PM_INIT;
      pm_q[2]    <= PM_INIT;
      pm_q[3]    <= PM_INIT;
      dec        <= '0;
      dec_valid  <= 1'b0;
      best_state <= '0;
      step_cnt   <= '0;
      frame_done <= 1'b0;
    end else if (init) begin
      pm_q[0]    <= '0;
      pm_q[1]    <= PM_INIT;
      pm_q[2]    <= PM_INIT;
      pm_q[3]    <= PM_INIT;
      dec        <= '0;
      dec_valid  <= 1'b0;
      best_state <= '0;
      step_cnt   <= '0;
      frame_done <= 1'b0;
    end else if (hamd_valid) begin
      for (int s = 0; s < 4; s++) begin
        pm_q[s] <= norm[s];
      end
      dec        <= dec_n;
      dec_valid  <= 1'b1;
      best_state <= best_n;
      step_cnt   <= (step_cnt == LAST_STEP) ? 3'd0 : step_cnt + 3'd1;
      frame_done <= (step_cnt == LAST_STEP);
    end else begin
      dec_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acs_unit.sv
// Scoreboard bench for acs_unit: stimulus pushes expected results, a
// negedge monitor pops and compares whenever dec_valid is presented.
module tb_acs_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       init;
  logic       hamd_valid;
  logic [1:0] hamd_1, hamd_2, hamd_3, hamd_4, hamd_5, hamd_6, hamd_7, hamd_8;
  logic [7:0] pm_0, pm_1, pm_2, pm_3;
  logic [3:0] dec;
  logic       dec_valid;
  logic [1:0] best_state;
  logic [2:0] step_cnt;
  logic       frame_done;

  typedef struct packed {
    logic [31:0] pm;
    logic [3:0]  dec;
    logic [1:0]  best;
    logic [2:0]  cnt;
    logic        fd;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   fd_count = 0;
  int   m_pm[4];
  int   m_cnt;

  // Received-symbol vectors packed {b1,...,b8}, hand-derived Hamming distances.
  localparam logic [15:0] RX00 = {2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1};
  localparam logic [15:0] RX11 = {2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd1};
  localparam logic [15:0] RX10 = {2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0};
  localparam logic [15:0] ALL2 = 16'hAAAA;

  acs_unit dut (
    .clk(clk), .rst(rst), .init(init), .hamd_valid(hamd_valid),
    .hamd_1(hamd_1), .hamd_2(hamd_2), .hamd_3(hamd_3), .hamd_4(hamd_4),
    .hamd_5(hamd_5), .hamd_6(hamd_6), .hamd_7(hamd_7), .hamd_8(hamd_8),
    .pm_0(pm_0), .pm_1(pm_1), .pm_2(pm_2), .pm_3(pm_3),
    .dec(dec), .dec_valid(dec_valid), .best_state(best_state),
    .step_cnt(step_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void model_reset();
    m_pm  = '{0, 16, 16, 16};
    m_cnt = 0;
  endfunction

  function automatic exp_t model_step(input logic [15:0] v);
    int   b[8];
    int   ca[4];
    int   cb[4];
    int   bi;
    exp_t e;
    for (int i = 0; i < 8; i++) b[i] = int'(v[15-2*i -: 2]);
    ca[0] = m_pm[0] + b[0]; cb[0] = m_pm[1] + b[4];
    ca[1] = m_pm[2] + b[2]; cb[1] = m_pm[3] + b[6];
    ca[2] = m_pm[0] + b[1]; cb[2] = m_pm[1] + b[5];
    ca[3] = m_pm[2] + b[3]; cb[3] = m_pm[3] + b[7];
    e.dec = 4'b0;
    for (int s = 0; s < 4; s++) begin
      if (ca[s] <= cb[s]) m_pm[s] = ca[s];
      else begin
        m_pm[s]  = cb[s];
        e.dec[s] = 1'b1;
      end
    end
    if (m_pm[0] >= 128 && m_pm[1] >= 128 && m_pm[2] >= 128 && m_pm[3] >= 128)
      for (int s = 0; s < 4; s++) m_pm[s] -= 128;
    bi = 0;
    for (int s = 1; s < 4; s++) if (m_pm[s] < m_pm[bi]) bi = s;
    e.pm   = {8'(m_pm[0]), 8'(m_pm[1]), 8'(m_pm[2]), 8'(m_pm[3])};
    e.best = 2'(bi);
    e.fd   = (m_cnt == 7);
    m_cnt  = (m_cnt + 1) % 8;
    e.cnt  = 3'(m_cnt);
    return e;
  endfunction

  // Called just after a rising edge; returns just after the edge that samples it.
  task automatic applyStimulus(input logic [15:0] v, input logic valid, input logic ini);
    {hamd_1, hamd_2, hamd_3, hamd_4, hamd_5, hamd_6, hamd_7, hamd_8} = v;
    hamd_valid = valid;
    init       = ini;
    if (ini) model_reset();
    else if (valid) sb.push_back(model_step(v));
    @(posedge clk);
    #1;
    hamd_valid = 1'b0;
    init       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(16'h0, 1'b0, 1'b0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pm"}, {pm_0, pm_1, pm_2, pm_3}, 32'h00101010);
    checkOutput({tag, "_dec"}, 32'(dec), 32'd0);
    checkOutput({tag, "_dec_valid"}, 32'(dec_valid), 32'd0);
    checkOutput({tag, "_step_cnt"}, 32'(step_cnt), 32'd0);
    checkOutput({tag, "_best"}, 32'(best_state), 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checkResetState("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dec_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_dec_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("sb_pm", {pm_0, pm_1, pm_2, pm_3}, e.pm);
          checkOutput("sb_dec", 32'(dec), 32'(e.dec));
          checkOutput("sb_best", 32'(best_state), 32'(e.best));
          checkOutput("sb_step_cnt", 32'(step_cnt), 32'(e.cnt));
          checkOutput("sb_frame_done", 32'(frame_done), 32'(e.fd));
        end
      end else begin
        checkOutput("frame_done_idle", 32'(frame_done), 32'd0);
      end
      if (frame_done) fd_count++;
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; init = 1'b0; hamd_valid = 1'b0;
    {hamd_1, hamd_2, hamd_3, hamd_4, hamd_5, hamd_6, hamd_7, hamd_8} = 16'h0;
    model_reset();
    @(posedge clk);
    #1;
    checkResetState("por");
    rst = 1'b0;

    $display("[TB] rx00 single step");
    applyStimulus(RX00, 1'b1, 1'b0);
    checkOutput("rx00_pm", {pm_0, pm_1, pm_2, pm_3}, 32'h00110211);
    checkOutput("rx00_dec_valid", 32'(dec_valid), 32'd1);
    checkOutput("rx00_best", 32'(best_state), 32'd0);
    applyStimulus(RX11, 1'b1, 1'b0);
    applyStimulus(RX10, 1'b1, 1'b0);

    $display("[TB] reset mid-operation");
    checkOutput("pre_rst_dec_valid", 32'(dec_valid), 32'd1);
    #1;
    rst = 1'b1;
    model_reset();
    sb.delete();
    #1;
    checkResetState("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] rx10 step and hold");
    applyStimulus(RX10, 1'b1, 1'b0);
    idle(3);
    checkOutput("hold_pm", {pm_0, pm_1, pm_2, pm_3}, 32'h01100110);
    checkOutput("hold_dec", 32'(dec), 32'b1000);
    checkOutput("hold_step_cnt", 32'(step_cnt), 32'd1);

    $display("[TB] rx11 single step");
    pulseReset();
    applyStimulus(RX11, 1'b1, 1'b0);
    checkOutput("rx11_pm", {pm_0, pm_1, pm_2, pm_3}, 32'h02110011);
    checkOutput("rx11_best", 32'(best_state), 32'd2);
    checkOutput("rx11_dec", 32'(dec), 32'd0);

    $display("[TB] all-2 metric growth and normalisation");
    pulseReset();
    for (int k = 1; k <= 64; k++) begin
      applyStimulus(ALL2, 1'b1, 1'b0);
      if (k == 2)  checkOutput("all2_step2", {pm_0, pm_1, pm_2, pm_3}, 32'h04040404);
      if (k == 63) checkOutput("all2_step63", {pm_0, pm_1, pm_2, pm_3}, 32'h7e7e7e7e);
      if (k == 64) checkOutput("all2_step64", {pm_0, pm_1, pm_2, pm_3}, 32'h00000000);
    end
    idle(1);

    $display("[TB] frame counting with gaps");
    pulseReset();
    fd_count = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(RX00, 1'b1, 1'b0);
      idle(2);
    end
    checkOutput("frame_pulses", 32'(fd_count), 32'd1);
    checkOutput("frame_step_cnt", 32'(step_cnt), 32'd0);
    fd_count = 0;
    for (int k = 0; k < 4; k++) applyStimulus(RX11, 1'b1, 1'b0);
    idle(1);
    applyStimulus(RX00, 1'b0, 1'b1);
    checkOutput("init_step_cnt", 32'(step_cnt), 32'd0);
    for (int k = 0; k < 7; k++) applyStimulus(RX10, 1'b1, 1'b0);
    idle(1);
    checkOutput("init_no_early_pulse", 32'(fd_count), 32'd0);
    applyStimulus(RX10, 1'b1, 1'b0);
    idle(1);
    checkOutput("init_pulse_after_8", 32'(fd_count), 32'd1);

    $display("[TB] init with simultaneous valid");
    for (int k = 0; k < 3; k++) applyStimulus(RX11, 1'b1, 1'b0);
    idle(1);
    applyStimulus(RX00, 1'b1, 1'b1);
    checkResetState("init_drop");
    idle(2);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acs_unit.md
Name: acs_unit

Overview:
- Add-compare-select stage of the rate-1/2, K=3 (7,5) Viterbi decoder.
- Sits directly downstream of the branch-metric unit and consumes its eight 2-bit Hamming distances hamd_1..hamd_8 each symbol step.
- Keeps four path metrics and emits one survivor-decision bit per state to the traceback memory.
- Counts 8 symbol steps per 16-bit input word and flags frame end.

Parameters:
- PM_W, 8, path-metric register width in bits.
- INIT_PM, 16, reset/init metric for states S1..S3. Must be < 2^(PM_W-2).
- FRAME_LEN, 8, symbol steps per frame (one 16-bit word).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- init  in  1  synchronous re-initialise of metrics and step counter.
- hamd_valid  in  1  hamd_1..hamd_8 hold a valid symbol this cycle.
- hamd_1..hamd_8  in  2 each  branch metrics, in branch order b1..b8.
- pm_0..pm_3  out  PM_W each  path metrics of states S0..S3 (registered).
- dec  out  4  survivor decision per state; bit s belongs to state Ss.
- dec_valid  out  1  dec and pm_* updated this cycle.
- best_state  out  2  index of the minimum path metric; lowest index wins ties.
- step_cnt  out  3  symbol index within the frame, 0..FRAME_LEN-1.
- frame_done  out  1  one-cycle pulse with the FRAME_LEN-th dec_valid of a frame.

Behaviour:
- State encoding: Ss = {s1,s0}. Next state = {u,s1}.
- Trellis, fixed to the branch-metric unit's order:
  - b1 S0->S0 (00), b2 S0->S2 (11), b3 S2->S1 (10), b4 S2->S3 (01)
  - b5 S1->S0 (11), b6 S1->S2 (00), b7 S3->S1 (01), b8 S3->S3 (10)
- ACS per state:
  - S0 = min(pm_0+b1, pm_1+b5)
  - S1 = min(pm_2+b3, pm_3+b7)
  - S2 = min(pm_0+b2, pm_1+b6)
  - S3 = min(pm_2+b4, pm_3+b8)
- Decision bit: dec[s]=0 when the first candidate is <= the second (ties select the first); dec[s]=1 otherwise.
- Width: each sum is computed in PM_W+1 bits. The compare uses the full width, so no overflow is possible.
- Normalisation: if all four selected metrics have bit PM_W-1 set, clear bit PM_W-1 in all four (subtract 2^(PM_W-1)) in the same cycle. Otherwise store them unchanged.
- Latency: one cycle. hamd_valid=1 at edge N gives pm_*, dec, best_state and dec_valid=1 after edge N. dec_valid is 0 on any cycle without hamd_valid.
- No hamd_valid: pm_*, dec, best_state and step_cnt hold their values.
- best_state: computed from the newly registered metrics and updated together with them.
- step_cnt: increments on each accepted step and wraps FRAME_LEN-1 -> 0. frame_done=1 on the step where step_cnt was FRAME_LEN-1.
- init=1 (synchronous): pm_0=0, pm_1..pm_3=INIT_PM, step_cnt=0, dec=0, dec_valid=0, frame_done=0, best_state=0.
  - init has priority over a simultaneous hamd_valid; that symbol is dropped.
- rst (asynchronous): the same values as init, applied immediately, including in the middle of a frame.

Decomposition:
- viterbi_pkg holds:
  - state encodings S0..S3
  - branch index constants B1..B8
  - the predecessor table
  - the default PM_W and INIT_PM values
- Sub-module acs_cell (two adders, comparator, mux, decision bit), instantiated four times. The normalisation logic, counter and argmin stay in acs_unit.

Test Plan:
- rst pulse mid-operation -> immediately pm=0,16,16,16, dec=0, dec_valid=0, step_cnt=0, best_state=0.
- After reset, one valid step with hamd=0,2,1,1,2,0,1,1 (rx 00) -> next cycle pm=0,17,2,17, dec=4'b0000, best_state=0, dec_valid=1.
- After reset, one valid step with hamd=2,0,1,1,0,2,1,1 (rx 11) -> pm=2,17,0,17, dec=4'b0000, best_state=2.
- After reset, all hamd=2 on every step -> step 2 gives pm=4,4,4,4. Step 63 gives 126 in all four. Step 64 gives 0 in all four (normalised), and no metric ever exceeds 255.
- 8 valid steps with idle gaps between them -> frame_done pulses exactly once, on the 8th step, and step_cnt reads 0 afterwards. init asserted at step 5 -> counter restarts and the next frame_done comes 8 steps later.
- init and hamd_valid asserted in the same cycle -> dec_valid=0 and pm=0,16,16,16; the symbol is not counted.
